sdram_ctrl: RTL

Timing/sequencing controller for the SDR SDRAM path. Runs power-up initialisation and auto-refresh scheduling, and arbitrates read and write requests from the FIFO side. Produces init_state, work_state, cnt_clk and sdram_rd_wr, which the downstream command encoder turns into pin-level commands. Generates the handshake acks and init-done flag for the requesters.

---
 rtl/sdram_ctrl_pkg.sv | 71 +++++++
 rtl/sdram_ref_timer.sv | 52 +++++
 rtl/sdram_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDR SDRAM controller: state and command encodings,
// timing defaults, burst clamping and the burst-stop strobes.
package sdram_ctrl_pkg;

  localparam int unsigned DEF_T_POWERUP   = 20000;
  localparam int unsigned DEF_T_RP        = 3;
  localparam int unsigned DEF_T_RFC       = 7;
  localparam int unsigned DEF_T_MRD       = 2;
  localparam int unsigned DEF_T_RCD       = 3;
  localparam int unsigned DEF_CAS_LAT     = 3;
  localparam int unsigned DEF_T_WR        = 2;
  localparam int unsigned DEF_INIT_AR_NUM = 8;
  localparam int unsigned DEF_REF_PERIOD  = 781;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_state_e;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_state_e;

  // {cs_n, ras_n, cas_n, we_n} as driven by the downstream command encoder.
  typedef enum logic [3:0] {
    CMD_INIT   = 4'b1111,
    CMD_NOP    = 4'b0111,
    CMD_ACTIVE = 4'b0011,
    CMD_READ   = 4'b0101,
    CMD_WRITE  = 4'b0100,
    CMD_B_STOP = 4'b0110,
    CMD_PRGE   = 4'b0010,
    CMD_A_REF  = 4'b0001,
    CMD_LMR    = 4'b0000
  } cmd_e;

  function automatic logic [9:0] clamp_burst(input logic [9:0] b);
    if (b < 10'd4)   return 10'd4;
    if (b > 10'd512) return 10'd512;
    return b;
  endfunction

  function automatic logic end_wrburst(input work_state_e st, input logic [9:0] cnt,
                                       input logic [9:0] burst);
    return (st == W_WD) && (cnt == burst - 10'd2);
  endfunction

  function automatic logic end_rdburst(input work_state_e st, input logic [9:0] cnt,
                                       input logic [9:0] burst, input logic [9:0] cas_lat);
    return (st == W_RD) && (cnt == burst - cas_lat - 10'd1);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: wraps every REF_PERIOD cycles once enabled and
// raises a pending flag that the working FSM clears when it enters W_AR.
module sdram_ref_timer
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic ref_pend
);

  localparam int TW = $clog2(REF_PERIOD);

  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          wrap;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    timer_d = timer_q;
    pend_d  = pend_q;
    wrap    = 1'b0;
    if (en) begin
      if (timer_q == TW'(REF_PERIOD - 1)) begin
        timer_d = '0;
        wrap    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    if (wrap) pend_d = 1'b1;
    // Servicing wins over a coincident wrap.
    if (clr)  pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      timer_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign ref_pend = pend_q;

endmodule

// File: rtl/sdram_ctrl.sv
// SDR SDRAM sequencing controller: power-up init, refresh scheduling and
// read/write arbitration, exposing state and cycle count to the command encoder.
module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned T_POWERUP   = DEF_T_POWERUP,
  parameter int unsigned T_RP        = DEF_T_RP,
  parameter int unsigned T_RFC       = DEF_T_RFC,
  parameter int unsigned T_MRD       = DEF_T_MRD,
  parameter int unsigned T_RCD       = DEF_T_RCD,
  parameter int unsigned CAS_LAT     = DEF_CAS_LAT,
  parameter int unsigned T_WR        = DEF_T_WR,
  parameter int unsigned INIT_AR_NUM = DEF_INIT_AR_NUM,
  parameter int unsigned REF_PERIOD  = DEF_REF_PERIOD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);

  localparam int ARW = $clog2(INIT_AR_NUM + 1);

  // Last cnt_clk value of each multi-cycle wait state.
  localparam logic [14:0]    PWR_END  = 15'(T_POWERUP - 1);
  localparam logic [9:0]     TRP_END  = 10'(T_RP - 2);
  localparam logic [9:0]     TRFC_END = 10'(T_RFC - 2);
  localparam logic [9:0]     TMRD_END = 10'(T_MRD - 2);
  localparam logic [9:0]     TRCD_END = 10'(T_RCD - 2);
  localparam logic [9:0]     CL_END   = 10'(CAS_LAT - 2);
  localparam logic [9:0]     TWR_END  = 10'(T_WR - 1);
  localparam logic [ARW-1:0] AR_NUM   = ARW'(INIT_AR_NUM);

  init_state_e    init_state_q, init_state_d;
  work_state_e    work_state_q, work_state_d;
  logic [9:0]     cnt_clk_q, cnt_clk_d;
  logic [14:0]    cnt_pwr_q, cnt_pwr_d;
  logic [ARW-1:0] ar_cnt_q, ar_cnt_d;
  logic [9:0]     wr_burst_q, wr_burst_d;
  logic [9:0]     rd_burst_q, rd_burst_d;
  logic           rd_wr_q, rd_wr_d;
  logic           wr_ack_q, wr_ack_d;
  logic           rd_ack_q, rd_ack_d;
  logic           init_done_q, init_done_d;
  logic           ref_pend, ref_clr, wr_go, rd_go;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (init_state_q == I_DONE),
    .clr      (ref_clr),
    .ref_pend (ref_pend)
  );

  always_comb begin
    init_state_d = init_state_q;
    work_state_d = work_state_q;
    cnt_pwr_d    = cnt_pwr_q;
    ar_cnt_d     = ar_cnt_q;
    wr_burst_d   = wr_burst_q;
    rd_burst_d   = rd_burst_q;
    rd_wr_d      = rd_wr_q;
    ref_clr      = 1'b0;
    // A zero-length burst is not a request at all.
    wr_go        = sdram_wr_req && (sdram_wr_burst != 10'd0);
    rd_go        = sdram_rd_req && (sdram_rd_burst != 10'd0);

    unique case (init_state_q)
      I_NOP:   if (cnt_pwr_q == PWR_END) init_state_d = I_PRE;
               else cnt_pwr_d = cnt_pwr_q + 15'd1;
      I_PRE:   init_state_d = I_TRP;
      I_TRP:   if (cnt_clk_q == TRP_END) init_state_d = I_AR;
      I_AR:    begin
                 init_state_d = I_TRF;
                 ar_cnt_d     = ar_cnt_q + 1'b1;
               end
      I_TRF:   if (cnt_clk_q == TRFC_END) begin
                 if (ar_cnt_q == AR_NUM) init_state_d = I_MRS;
                 else                    init_state_d = I_AR;
               end
      I_MRS:   init_state_d = I_TRSC;
      I_TRSC:  if (cnt_clk_q == TMRD_END) init_state_d = I_DONE;
      default: init_state_d = I_DONE;
    endcase

    if (init_state_q != I_DONE) begin
      work_state_d = W_IDLE;
    end else begin
      unique case (work_state_q)
        W_IDLE:   if (ref_pend) begin
                    work_state_d = W_AR;
                    ref_clr      = 1'b1;
                  end else if (wr_go || rd_go) begin
                    work_state_d = W_ACTIVE;
                    rd_wr_d      = !wr_go;
                    wr_burst_d   = clamp_burst(sdram_wr_burst);
                    rd_burst_d   = clamp_burst(sdram_rd_burst);
                  end
        W_ACTIVE: work_state_d = W_TRCD;
        W_TRCD:   if (cnt_clk_q == TRCD_END) begin
                    if (rd_wr_q) work_state_d = W_READ;
                    else         work_state_d = W_WRITE;
                  end
        W_READ:   work_state_d = W_CL;
        W_CL:     if (cnt_clk_q == CL_END) work_state_d = W_RD;
        W_RD:     if (cnt_clk_q == rd_burst_q - 10'd1) work_state_d = W_PRE;
        W_WRITE:  work_state_d = W_WD;
        W_WD:     if (end_wrburst(work_state_q, cnt_clk_q, wr_burst_q)) work_state_d = W_TWR;
        W_TWR:    if (cnt_clk_q == TWR_END) work_state_d = W_PRE;
        W_PRE:    work_state_d = W_TRP;
        W_TRP:    if (cnt_clk_q == TRP_END) work_state_d = W_IDLE;
        W_AR:     work_state_d = W_TRFC;
        W_TRFC:   if (cnt_clk_q == TRFC_END) work_state_d = W_IDLE;
        default:  work_state_d = W_IDLE;
      endcase
    end

    if ((init_state_d != init_state_q) || (work_state_d != work_state_q)) cnt_clk_d = '0;
    else if (cnt_clk_q == 10'h3FF)                                        cnt_clk_d = cnt_clk_q;
    else                                                                   cnt_clk_d = cnt_clk_q + 10'd1;

    wr_ack_d    = (work_state_d == W_WRITE) || (work_state_d == W_WD);
    rd_ack_d    = (work_state_q == W_RD);
    init_done_d = (init_state_q == I_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_state_q <= I_NOP;
      work_state_q <= W_IDLE;
      cnt_clk_q    <= '0;
      cnt_pwr_q    <= '0;
      ar_cnt_q     <= '0;
      wr_burst_q   <= 10'd4;
      rd_burst_q   <= 10'd4;
      rd_wr_q      <= 1'b1;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      init_state_q <= init_state_d;
      work_state_q <= work_state_d;
      cnt_clk_q    <= cnt_clk_d;
      cnt_pwr_q    <= cnt_pwr_d;
      ar_cnt_q     <= ar_cnt_d;
      wr_burst_q   <= wr_burst_d;
      rd_burst_q   <= rd_burst_d;
      rd_wr_q      <= rd_wr_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      init_done_q  <= init_done_d;
    end
  end

  assign init_state      = init_state_q;
  assign work_state      = work_state_q;
  assign cnt_clk         = cnt_clk_q;
  assign sdram_rd_wr     = rd_wr_q;
  assign sdram_wr_ack    = wr_ack_q;
  assign sdram_rd_ack    = rd_ack_q;
  assign sdram_init_done = init_done_q;

endmodule
